cpu_sequencer: RTL and testbench

//  Multi-cycle control sequencer for the Jac1-8 core.
//  - Fetches 16-bit instructions from program memory over a req/ack handshake.
//  - Holds each instruction in an instruction register that drives the combinational decoder.
//  - Gates the decoder's raw enables so that register-file, status and PC writes happen in exactly one cycle per instruction.
//  - Owns the program counter; traps on reserved opcodes.

---
 rtl/cpu_sequencer.sv | 151 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Jac1-8 multi-cycle control sequencer: fetch handshake, instruction
// register, single-cycle write-back gating, program counter and trap.
module cpu_sequencer #(
  parameter int PC_WIDTH          = 8,
  parameter int PROGRAM_DataWidth = 16,
  parameter int NumOpCodeBits     = 5,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic                         step,
  output logic                         prog_req,
  output logic [PC_WIDTH-1:0]          prog_addr,
  input  logic                         prog_ack,
  input  logic [PROGRAM_DataWidth-1:0] prog_data,
  output logic [PROGRAM_DataWidth-1:0] instr,
  input  logic                         dec_wr_en,
  input  logic                         dec_stat_wr_en,
  input  logic                         dec_cnt_wr_en,
  input  logic                         dec_add_offset,
  input  logic [PC_WIDTH-1:0]          dec_literal_adr,
  output logic                         rf_wr_en,
  output logic                         stat_wr_en,
  output logic [PC_WIDTH-1:0]          pc,
  output logic                         halted,
  output logic                         illegal,
  output logic [CNT_WIDTH-1:0]         retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_TRAP
  } state_t;

  state_t                         r_state;
  logic [PC_WIDTH-1:0]            r_pc;
  logic [PROGRAM_DataWidth-1:0]   r_instr;
  logic [CNT_WIDTH-1:0]           r_retired;
  logic                           r_single;
  logic                           r_req;
  logic                           r_halted;
  logic                           r_illegal;

  logic [NumOpCodeBits-1:0]       w_op;
  logic                           w_reserved;
  logic [PC_WIDTH-1:0]            w_pc_nxt;
  logic                           w_wb;

  assign w_op = r_instr[PROGRAM_DataWidth-1 -: NumOpCodeBits];

  // Reserved opcodes: 0x0D..0x0F and 0x16..0x1F
  always_comb begin
    w_reserved = 1'b0;
    unique case (1'b1)
      (w_op >= NumOpCodeBits'(13)) && (w_op <= NumOpCodeBits'(15)):
        w_reserved = 1'b1;
      (w_op >= NumOpCodeBits'(22)):
        w_reserved = 1'b1;
      default:
        w_reserved = 1'b0;
    endcase
  end

  always_comb begin
    w_pc_nxt = r_pc + PC_WIDTH'(1);
    unique case (1'b1)
      dec_cnt_wr_en & dec_add_offset:
        w_pc_nxt = r_pc + dec_literal_adr;
      dec_cnt_wr_en & ~dec_add_offset:
        w_pc_nxt = dec_literal_adr;
      default:
        w_pc_nxt = r_pc + PC_WIDTH'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_instr   <= '0;
      r_retired <= '0;
      r_single  <= 1'b0;
      r_req     <= 1'b0;
      r_halted  <= 1'b1;
      r_illegal <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (run | step) begin
            r_state  <= S_FETCH;
            r_single <= ~run;
            r_req    <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        S_FETCH: begin
          if (prog_ack) begin
            r_instr <= prog_data;
            r_state <= S_DECODE;
            r_req   <= 1'b0;
          end
        end
        S_DECODE: begin
          if (w_reserved) begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
            r_halted  <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: r_state <= S_WB;
        S_WB: begin
          r_pc      <= w_pc_nxt;
          r_retired <= r_retired + CNT_WIDTH'(1);
          r_single  <= 1'b0;
          if (run & ~r_single) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end else begin
            r_state  <= S_IDLE;
            r_halted <= 1'b1;
          end
        end
        S_TRAP: r_state <= S_TRAP;
        default: begin
          r_state  <= S_IDLE;
          r_req    <= 1'b0;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

  assign w_wb       = (r_state == S_WB);
  assign rf_wr_en   = w_wb & dec_wr_en;
  assign stat_wr_en = w_wb & dec_stat_wr_en;
  assign prog_req   = r_req;
  assign prog_addr  = r_pc;
  assign pc         = r_pc;
  assign instr      = r_instr;
  assign halted     = r_halted;
  assign illegal    = r_illegal;
  assign retired    = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: memory responder, toy decoder and a
// retirement scoreboard checking pc, latency and write strobes.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        step;
  logic        prog_req;
  logic [7:0]  prog_addr;
  logic        prog_ack;
  logic [15:0] prog_data;
  logic [15:0] instr;
  logic        dec_wr_en;
  logic        dec_stat_wr_en;
  logic        dec_cnt_wr_en;
  logic        dec_add_offset;
  logic [7:0]  dec_literal_adr;
  logic        rf_wr_en;
  logic        stat_wr_en;
  logic [7:0]  pc;
  logic        halted;
  logic        illegal;
  logic [15:0] retired;

  cpu_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .run             (run),
    .step            (step),
    .prog_req        (prog_req),
    .prog_addr       (prog_addr),
    .prog_ack        (prog_ack),
    .prog_data       (prog_data),
    .instr           (instr),
    .dec_wr_en       (dec_wr_en),
    .dec_stat_wr_en  (dec_stat_wr_en),
    .dec_cnt_wr_en   (dec_cnt_wr_en),
    .dec_add_offset  (dec_add_offset),
    .dec_literal_adr (dec_literal_adr),
    .rf_wr_en        (rf_wr_en),
    .stat_wr_en      (stat_wr_en),
    .pc              (pc),
    .halted          (halted),
    .illegal         (illegal),
    .retired         (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint act,
                     input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // toy encoding: op[15:11], Z flag in bit 10, literal in [7:0]
  function automatic logic [15:0] enc(input logic [4:0] op,
                                      input logic z,
                                      input logic [7:0] lit);
    return {op, z, 2'b00, lit};
  endfunction

  logic [4:0] w_op;
  always_comb begin
    w_op            = instr[15:11];
    dec_wr_en       = (w_op == 5'd1) || (w_op == 5'd2);
    dec_stat_wr_en  = (w_op == 5'd1);
    dec_cnt_wr_en   = (w_op == 5'd3) || ((w_op == 5'd4) && instr[10]);
    dec_add_offset  = (w_op == 5'd4);
    dec_literal_adr = instr[7:0];
  end

  logic [15:0] mem [256];
  int          wait_tab [256];
  logic        stray;
  int          wcnt;

  always @(negedge clk) begin
    if (prog_req) begin
      if (wcnt >= wait_tab[prog_addr]) begin
        prog_ack  = 1'b1;
        prog_data = mem[prog_addr];
      end else begin
        prog_ack  = 1'b0;
        prog_data = 16'hDEAD;
        wcnt++;
      end
    end else begin
      wcnt      = 0;
      prog_ack  = stray;
      prog_data = 16'hFFFF;
    end
  end

  typedef struct {
    int pc;
    int ret;
    int lat;
    int wr;
    int req;
  } exp_t;
  exp_t sb [$];

  function automatic void push(input int p, input int r, input int l,
                               input int w, input int q);
    exp_t e;
    e.pc = p; e.ret = r; e.lat = l; e.wr = w; e.req = q;
    sb.push_back(e);
  endfunction

  logic        mon_en;
  int          cyc, wr_cnt, wr_cyc, req_cnt;
  int          addr_bad, instr_bad;
  logic        prev_req;
  logic [7:0]  prev_addr;
  logic [15:0] prev_instr;
  logic [15:0] last_ret;

  always @(negedge clk) begin
    if (mon_en && (retired !== last_ret)) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", retired, last_ret);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc", pc, e.pc);
        chk("sb_ret", retired, e.ret);
        chk("sb_lat", cyc, e.lat);
        chk("sb_wr_n", wr_cnt, e.wr);
        if (e.wr != 0) chk("sb_wr_cyc", wr_cyc, e.lat);
        chk("sb_req_n", req_cnt, e.req);
      end
    end
    last_ret = retired;
    if (prog_req && !prev_req) begin
      cyc = 1; wr_cnt = 0; req_cnt = 0;
    end else begin
      cyc++;
    end
    if (prog_req) begin
      req_cnt++;
      if (prev_req && prog_addr !== prev_addr) addr_bad++;
      if (prev_req && instr !== prev_instr) instr_bad++;
    end
    if (rf_wr_en) begin
      wr_cnt++;
      wr_cyc = cyc;
    end
    prev_req   = prog_req;
    prev_addr  = prog_addr;
    prev_instr = instr;
  end

  task automatic do_step();
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (6) @(negedge clk);
    chk("step_halted", halted, 1);
  endtask

  task automatic stop_in_exec(input logic [7:0] a);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      if (prog_ack && prog_addr == a) found = 1;
    end
    chk("stop_found", found, 1);
    @(posedge clk);
    #1 run = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; step = 1'b0; stray = 1'b0;
    mon_en = 1'b1; wcnt = 0; prog_ack = 1'b0; prog_data = '0;
    cyc = 0; wr_cnt = 0; wr_cyc = 0; req_cnt = 0;
    addr_bad = 0; instr_bad = 0; prev_req = 0;
    prev_addr = 0; prev_instr = 0; last_ret = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      wait_tab[i] = 0;
    end
    mem[8'h00] = enc(5'd1, 1'b0, 8'h12);
    mem[8'h01] = enc(5'd2, 1'b0, 8'hA5);
    mem[8'h02] = enc(5'd3, 1'b0, 8'h10);
    mem[8'h10] = enc(5'd3, 1'b0, 8'h3F);
    mem[8'h3F] = enc(5'd0, 1'b0, 8'h00);
    wait_tab[8'h3F] = 3;
    mem[8'h40] = enc(5'd3, 1'b0, 8'h20);
    push(8'h01, 1, 4, 1, 1);
    push(8'h02, 2, 4, 1, 1);
    push(8'h10, 3, 4, 0, 1);
    push(8'h3F, 4, 4, 0, 1);
    push(8'h40, 5, 7, 0, 4);
    push(8'h20, 6, 4, 0, 1);

    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_req", prog_req, 0);
    chk("rst_halted", halted, 1);
    chk("rst_rf_wr", rf_wr_en, 0);
    chk("rst_retired", retired, 0);
    chk("rst_illegal", illegal, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req", prog_req, 1);
    chk("rel_halted", halted, 0);

    stop_in_exec(8'h40);
    repeat (4) @(negedge clk);
    chk("stop_halted", halted, 1);
    chk("stop_req", prog_req, 0);
    chk("stop_pc", pc, 8'h20);

    stray = 1'b1;
    repeat (2) @(negedge clk);
    stray = 1'b0;
    chk("stray_instr", instr, enc(5'd3, 1'b0, 8'h20));
    chk("stray_req", prog_req, 0);

    mem[8'h20] = enc(5'd4, 1'b1, 8'h09);
    push(8'h29, 7, 4, 0, 1);
    do_step();
    mem[8'h29] = enc(5'd3, 1'b0, 8'h20);
    push(8'h20, 8, 4, 0, 1);
    do_step();
    mem[8'h20] = enc(5'd4, 1'b0, 8'h09);
    push(8'h21, 9, 4, 0, 1);
    do_step();
    mem[8'h21] = enc(5'd3, 1'b0, 8'h20);
    push(8'h20, 10, 4, 0, 1);
    do_step();
    mem[8'h20] = enc(5'd4, 1'b1, 8'hF0);
    push(8'h10, 11, 4, 0, 1);
    do_step();
    mem[8'h10] = enc(5'd3, 1'b0, 8'h05);
    push(8'h05, 12, 4, 0, 1);
    do_step();

    mem[8'h05] = enc(5'h1D, 1'b0, 8'h00);
    do_step();
    chk("trap_illegal", illegal, 1);
    chk("trap_pc", pc, 8'h05);
    chk("trap_wr_n", wr_cnt, 0);
    chk("trap_retired", retired, 12);
    do_step();
    chk("trap_stay", illegal, 1);
    chk("trap_req", prog_req, 0);

    @(negedge clk);
    mon_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("trst_illegal", illegal, 0);
    chk("trst_halted", halted, 1);
    mem[8'h00] = enc(5'd1, 1'b0, 8'h00);
    wait_tab[8'h00] = 20;
    rst_n = 1'b1;
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("wait_req", prog_req, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", prog_req, 0);
    chk("mid_rst_halted", halted, 1);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_retired", retired, 0);
    run = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    chk("sb_left", sb.size(), 0);
    chk("addr_stable", addr_bad, 0);
    chk("instr_stable", instr_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
